// File: rtl/reg_file_mp_if.sv
// Register-file access bundle: read ports, two write ports and scoreboard set.
// The master drives addresses and writes; the slave returns combinational read data and pending state.
interface reg_file_mp_if #(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*AW-1:0] rd_addr;
    logic [NUM_RD*DW-1:0] rd_data;
    logic [NUM_RD-1:0]    rd_pend;
    logic                 we0;
    logic [AW-1:0]        wa0;
    logic [DW-1:0]        wd0;
    logic                 we1;
    logic [AW-1:0]        wa1;
    logic [DW-1:0]        wd1;
    logic                 pend_set;
    logic [AW-1:0]        pend_addr;
    logic                 pend_any;

    modport master (
        output rd_addr, we0, wa0, wd0, we1, wa1, wd1, pend_set, pend_addr,
        input  rd_data, rd_pend, pend_any
    );

    modport slave (
        input  rd_addr, we0, wa0, wd0, we1, wa1, wd1, pend_set, pend_addr,
        output rd_data, rd_pend, pend_any
    );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file with write-port-1 priority, optional write bypass and a per-register pending scoreboard.
// Reads are 0-cycle combinational, writes land in 1 cycle; no backpressure, every request is accepted.
module reg_file_mp #(
    parameter int DW       = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    reg_file_mp_if.slave  bus
);

    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] pend;

    for (genvar r = 0; r < DEPTH; r++) begin : g_reg
        localparam logic [AW-1:0] ADDR  = AW'(r);
        localparam bit            FIXED = (ZERO_REG != 0) && (r == 0);

        logic          hit0;
        logic          hit1;
        logic          hit_set;
        logic [DW-1:0] data_q;
        logic          pend_q;

        assign hit0    = !FIXED && bus.we0 && (bus.wa0 == ADDR);
        assign hit1    = !FIXED && bus.we1 && (bus.wa1 == ADDR);
        assign hit_set = !FIXED && bus.pend_set && (bus.pend_addr == ADDR);

        // A producer issuing in the same cycle as a writeback keeps the register pending.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q <= '0;
                pend_q <= 1'b0;
            end else begin
                if (hit1) begin
                    data_q <= bus.wd1;
                end else if (hit0) begin
                    data_q <= bus.wd0;
                end

                if (hit_set) begin
                    pend_q <= 1'b1;
                end else if (hit0 || hit1) begin
                    pend_q <= 1'b0;
                end
            end
        end

        assign mem[r]  = data_q;
        assign pend[r] = pend_q;
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0] addr;
        logic [DW-1:0] dat;
        logic          is_zero;

        assign addr    = bus.rd_addr[k*AW +: AW];
        assign is_zero = (ZERO_REG != 0) && (addr == '0);

        // Bypass is suppressed in reset so every read returns the cleared storage.
        always_comb begin
            dat = mem[addr];
            if ((BYPASS != 0) && rst_n && bus.we0 && (bus.wa0 == addr)) begin
                dat = bus.wd0;
            end
            if ((BYPASS != 0) && rst_n && bus.we1 && (bus.wa1 == addr)) begin
                dat = bus.wd1;
            end
            if (is_zero) begin
                dat = '0;
            end
        end

        assign bus.rd_data[k*DW +: DW] = dat;
        assign bus.rd_pend[k]          = pend[addr] && !is_zero;
    end

    assign bus.pend_any = |pend;

endmodule
